// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: req/ack data-memory access, lane steering, MEM/WB register.
// Optional MISALIGN_TRAP_EN: misaligned LW/LH/SH raise w_exc instead of being force-aligned.
module mem_stage_lsu #(
  parameter int unsigned AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m_valid,
  input  logic [1:0]    m_memwrite,
  input  logic          m_memtoreg,
  input  logic          m_half,
  input  logic          m_b,
  input  logic          m_bunsigned,
  input  logic          m_regwrite,
  input  logic [4:0]    m_writereg,
  input  logic [31:0]   m_aluout,
  input  logic [31:0]   m_writedata,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [3:0]    dmem_be,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic          dmem_ack,
  input  logic [31:0]   dmem_rdata,
  output logic          w_valid,
  output logic          w_regwrite,
  output logic [4:0]    w_writereg,
  output logic [31:0]   w_result,
  output logic          w_exc
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  logic [0:0]  state_q;
  logic        is_store, is_access, is_half, is_byte, is_word, misalign;
  logic [1:0]  lane;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  // Access context held for the whole WAIT period
  logic [1:0]  lane_q;
  logic        half_q, byte_q, uns_q, regwrite_q;
  logic [4:0]  writereg_q;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign is_store  = m_memwrite != 2'b00;
  assign is_access = m_memtoreg | is_store;
  assign is_half   = is_store ? (m_memwrite == 2'b10) : m_half;
  assign is_byte   = is_store ? (m_memwrite == 2'b11) : m_b;
  assign is_word   = ~is_half & ~is_byte;

`ifdef MISALIGN_TRAP_EN
  // Misaligned SW is not trapped: the word address already ignores the low bits
  assign misalign = m_memtoreg ? ((is_word & (m_aluout[1:0] != 2'b00)) | (is_half & m_aluout[0]))
                               : ((m_memwrite == 2'b10) & m_aluout[0]);
`else
  assign misalign = 1'b0;
`endif

  // Offending low address bits are dropped so the lane matches the forced-aligned access
  always_comb begin
    lane = m_aluout[1:0];
    if (is_word)      lane = 2'b00;
    else if (is_half) lane = {m_aluout[1], 1'b0};
  end

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = m_writedata;
    if (is_half) begin
      be_d    = lane[1] ? 4'b1100 : 4'b0011;
      wdata_d = {2{m_writedata[15:0]}};
    end else if (is_byte) begin
      be_d    = 4'b0001 << lane;
      wdata_d = {4{m_writedata[7:0]}};
    end
  end

  always_comb begin
    stall = 1'b0;
    if (state_q == StIdle) stall = m_valid & is_access & ~misalign;
    else                   stall = ~dmem_ack;
  end

  assign ld_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
  assign ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    ld_data = dmem_rdata;
    if (byte_q)      ld_data = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
    else if (half_q) ld_data = {{16{ld_half[15] & ~uns_q}}, ld_half};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_be    <= 4'b0000;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      lane_q     <= 2'b00;
      half_q     <= 1'b0;
      byte_q     <= 1'b0;
      uns_q      <= 1'b0;
      regwrite_q <= 1'b0;
      writereg_q <= 5'd0;
      w_valid    <= 1'b0;
      w_regwrite <= 1'b0;
      w_writereg <= 5'd0;
      w_result   <= '0;
      w_exc      <= 1'b0;
    end else if (state_q == StIdle) begin
      w_exc <= 1'b0;
      if (!m_valid) begin
        w_valid    <= 1'b0;
        w_regwrite <= 1'b0;
      end else if (misalign) begin
        w_valid    <= 1'b1;
        w_regwrite <= 1'b0;
        w_writereg <= m_writereg;
        w_result   <= m_aluout;
        w_exc      <= 1'b1;
      end else if (is_access) begin
        state_q    <= StWait;
        dmem_req   <= 1'b1;
        dmem_we    <= is_store;
        dmem_be    <= be_d;
        dmem_addr  <= {m_aluout[AW-1:2], 2'b00};
        dmem_wdata <= wdata_d;
        lane_q     <= lane;
        half_q     <= is_half;
        byte_q     <= is_byte;
        uns_q      <= m_bunsigned;
        regwrite_q <= m_regwrite & ~is_store;
        writereg_q <= m_writereg;
        w_valid    <= 1'b0;
        w_regwrite <= 1'b0;
      end else begin
        w_valid    <= 1'b1;
        w_regwrite <= m_regwrite;
        w_writereg <= m_writereg;
        w_result   <= m_aluout;
      end
    end else begin
      if (dmem_ack) begin
        state_q    <= StIdle;
        dmem_req   <= 1'b0;
        w_valid    <= 1'b1;
        w_regwrite <= regwrite_q;
        w_writereg <= writereg_q;
        w_result   <= ld_data;
      end else begin
        w_valid    <= 1'b0;
        w_regwrite <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory-stage load/store unit of the pipelined MIPS core. It sits between the EX/MEM pipeline register and the MEM/WB register, downstream of the main decoder's memory controls (memwrite, memtoreg, half/byte size, unsigned-load flag). It performs the data-memory access for LW/LH/LB/LBU/SW/SH/SB through a req/ack handshake, builds byte enables, lane-shifts store data and aligns/extends load data. It stalls the pipeline while an access is outstanding and owns the MEM/WB register.

## Interface
Parameters:
- AW, 32, data-memory address width
- none other; data path fixed at 32 bits

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- m_valid  in  1  EX/MEM slot holds a valid instruction
- m_memwrite  in  2  store type: 00 none, 01 SW, 10 SH, 11 SB
- m_memtoreg  in  1  instruction is a load
- m_half  in  1  load is halfword
- m_b  in  1  load is byte (m_half and m_b never both 1)
- m_bunsigned  in  1  zero-extend sub-word load
- m_regwrite  in  1  passed to WB
- m_writereg  in  5  destination register, passed to WB
- m_aluout  in  32  effective address / ALU result
- m_writedata  in  32  store data (rt)
- stall  out  1  hold IF/ID/EX and EX/MEM
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  write access
- dmem_be  out  4  byte enables
- dmem_addr  out  AW  word-aligned address (low 2 bits 0)
- dmem_wdata  out  32  lane-shifted store data
- dmem_ack  in  1  one-cycle access completion
- dmem_rdata  in  32  read data, valid with ack
- w_valid, w_regwrite  out  1  MEM/WB valid and register write
- w_writereg  out  5  MEM/WB destination
- w_result  out  32  aligned load data or ALU result
- w_exc  out  1  misaligned-access exception (only with MISALIGN_TRAP_EN)

## Operation
- States: IDLE, WAIT.
- IDLE, m_valid, no access: MEM/WB loads m_aluout and controls at next edge; stall=0.
- IDLE, m_valid, access (m_memtoreg or m_memwrite!=0): stall=1 combinationally; next edge -> WAIT, latch address, be, wdata, we, size, unsigned, writereg, regwrite; dmem_req=1 from that edge.
- WAIT: dmem_req/addr/be/wdata/we stable until dmem_ack. Ack cycle: stall=0, dmem_req deasserted at next edge, MEM/WB loaded, -> IDLE. WAIT without ack: stall=1, w_valid=0.
- Byte enables, a=addr[1:0]: SW 1111; SH a[1]?1100:0011; SB 0001<<a; loads: same masks by size.
- Store data: SW as-is; SH {2{wd[15:0]}}; SB {4{wd[7:0]}}.
- Load: byte lane rdata[8a+7:8a], half lane rdata[16a[1]+15:16a[1]]; sign-extend unless m_bunsigned; LW unmodified.
- Stores write MEM/WB with w_regwrite=0.
- m_valid=0 in IDLE: w_valid=0 next edge.

## Timing
- Reset values: state IDLE; stall 0; dmem_req 0, dmem_we 0, dmem_be 0, dmem_addr 0, dmem_wdata 0; w_valid 0, w_regwrite 0, w_writereg 0, w_result 0, w_exc 0.
- Non-memory op: 1 cycle to MEM/WB.
- Memory op: accept at C0, dmem_req at C1, earliest ack C1, w_valid at C2; each extra ack-wait cycle adds one.
- dmem_ack in IDLE is ignored.
- Reset mid-WAIT: dmem_req drops immediately, access abandoned, no MEM/WB write.

## Configuration
- MISALIGN_TRAP_EN defined: LW with a!=0 or LH/SH with a[0]=1 issues no dmem_req; next edge w_valid=1, w_exc=1, w_regwrite=0, stall=0. Undefined: w_exc tied 0; offending low address bits forced to 0 (LW/SW to a=00, LH/SH to a[0]=0) and access proceeds.

## Test plan
- Reset during WAIT with dmem_req=1 -> dmem_req=0 same cycle, state IDLE, w_valid=0.
- SB, aluout=0x1003, writedata=0x000000A5 -> dmem_be=1000, dmem_wdata=0xA5A5A5A5, dmem_addr=0x1000, w_regwrite=0.
- LB at 0x2002, rdata=0x12F43456, ack after 3 wait cycles -> stall high 4 cycles, w_result=0xFFFFFFF4; LBU same -> 0x000000F4.
- LH at 0x2002, rdata=0x80011234 -> w_result=0xFFFF8001; dmem_be=1100.
- ADD (no access) back-to-back after SW ack -> w_valid each cycle, stall 0, no dmem_req.
- LW at 0x3001: with MISALIGN_TRAP_EN -> no dmem_req, w_exc=1; without -> dmem_addr=0x3000, be=1111, w_exc=0.
